// File: rtl/sca_exec_window_ctrl.sv
// ============================================================================
// Module      : sca_exec_window_ctrl
// Description : Turns one start strobe into a programmable train of execution
//               windows (pre-delay, REP windows of LEN cycles, GAP idle cycles
//               between them), gated per channel by a mask. Also drives a scope
//               trigger pulse at each window start and busy/done status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sca_exec_window_ctrl #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int REP_W   = 4,
    parameter int DEF_LEN = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_cfg_we,
    input  logic [CNT_W-1:0]  i_cfg_delay,
    input  logic [CNT_W-1:0]  i_cfg_len,
    input  logic [CNT_W-1:0]  i_cfg_gap,
    input  logic [REP_W-1:0]  i_cfg_rep,
    input  logic [NUM_CH-1:0] i_cfg_mask,
    output logic [NUM_CH-1:0] o_enable,
    output logic              o_trig_out,
    output logic              o_busy,
    output logic              o_done,
    output logic [REP_W-1:0]  o_win_idx
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DELAY  = 3'd1,
        S_ACTIVE = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t             r_state;

    // Programmed configuration (written only while idle)
    logic [CNT_W-1:0]   r_cfg_delay;
    logic [CNT_W-1:0]   r_cfg_len;
    logic [CNT_W-1:0]   r_cfg_gap;
    logic [REP_W-1:0]   r_cfg_rep;
    logic [NUM_CH-1:0]  r_cfg_mask;

    // Run shadow: frozen at start so later writes cannot disturb a run
    logic [CNT_W-1:0]   r_sh_len_m1;
    logic [CNT_W-1:0]   r_sh_gap;
    logic [NUM_CH-1:0]  r_sh_mask;
    logic [REP_W-1:0]   r_rem;          // windows still to open after the current one
    logic [CNT_W-1:0]   r_cnt;          // down-counter, phase ends when it reaches 0

    logic [NUM_CH-1:0]  r_enable;
    logic               r_trig;
    logic               r_busy;
    logic               r_done;
    logic [REP_W-1:0]   r_win_idx;

    // A write in the same cycle as start must be seen by that run, so the
    // start path looks through the write port rather than the config regs.
    logic [CNT_W-1:0]   w_sel_delay;
    logic [CNT_W-1:0]   w_sel_len;
    logic [CNT_W-1:0]   w_sel_gap;
    logic [REP_W-1:0]   w_sel_rep;
    logic [NUM_CH-1:0]  w_sel_mask;
    logic [CNT_W-1:0]   w_sel_len_m1;
    logic [REP_W-1:0]   w_sel_rep_m1;
    logic [CNT_W-1:0]   w_gap_m1;
    logic               w_cnt_zero;
    logic               w_cfg_wr;

    assign w_cfg_wr     = (r_state == S_IDLE) && i_cfg_we;
    assign w_sel_delay  = i_cfg_we ? i_cfg_delay : r_cfg_delay;
    assign w_sel_len    = i_cfg_we ? i_cfg_len   : r_cfg_len;
    assign w_sel_gap    = i_cfg_we ? i_cfg_gap   : r_cfg_gap;
    assign w_sel_rep    = i_cfg_we ? i_cfg_rep   : r_cfg_rep;
    assign w_sel_mask   = i_cfg_we ? i_cfg_mask  : r_cfg_mask;

    // Length and repeat of 0 behave as 1, so their "minus one" floors at 0
    assign w_sel_len_m1 = (w_sel_len == '0) ? '0 : (w_sel_len - CNT_W'(1));
    assign w_sel_rep_m1 = (w_sel_rep == '0) ? '0 : (w_sel_rep - REP_W'(1));
    assign w_gap_m1     = r_sh_gap - CNT_W'(1);
    assign w_cnt_zero   = (r_cnt == '0);

    // Configuration register file, writable only while no run is in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg_delay <= '0;
            r_cfg_len   <= CNT_W'(DEF_LEN);
            r_cfg_gap   <= '0;
            r_cfg_rep   <= REP_W'(1);
            r_cfg_mask  <= '1;
        end else if (w_cfg_wr) begin
            r_cfg_delay <= i_cfg_delay;
            r_cfg_len   <= i_cfg_len;
            r_cfg_gap   <= i_cfg_gap;
            r_cfg_rep   <= i_cfg_rep;
            r_cfg_mask  <= i_cfg_mask;
        end
    end

    // Window sequencer with registered outputs; abort overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sh_len_m1 <= '0;
            r_sh_gap    <= '0;
            r_sh_mask   <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_enable    <= '0;
            r_trig      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_win_idx   <= '0;
        end else if ((r_state != S_IDLE) && i_abort) begin
            r_state  <= S_IDLE;
            r_enable <= '0;
            r_trig   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_trig <= 1'b0;
                    r_done <= 1'b0;
                    if (i_start && !i_abort) begin
                        r_sh_len_m1 <= w_sel_len_m1;
                        r_sh_gap    <= w_sel_gap;
                        r_sh_mask   <= w_sel_mask;
                        r_rem       <= w_sel_rep_m1;
                        r_win_idx   <= '0;
                        r_busy      <= 1'b1;
                        if (w_sel_delay != '0) begin
                            r_state  <= S_DELAY;
                            r_cnt    <= w_sel_delay - CNT_W'(1);
                            r_enable <= '0;
                        end else begin
                            r_state  <= S_ACTIVE;
                            r_cnt    <= w_sel_len_m1;
                            r_enable <= w_sel_mask;
                            r_trig   <= 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (w_cnt_zero) begin
                        r_state  <= S_ACTIVE;
                        r_cnt    <= r_sh_len_m1;
                        r_enable <= r_sh_mask;
                        r_trig   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_ACTIVE: begin
                    r_trig <= 1'b0;
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_rem == '0) begin
                        r_state  <= S_DONE;
                        r_enable <= '0;
                        r_done   <= 1'b1;
                    end else if (r_sh_gap != '0) begin
                        r_state  <= S_GAP;
                        r_cnt    <= w_gap_m1;
                        r_enable <= '0;
                    end else begin
                        // Abutting windows: enable stays high, trigger re-fires
                        r_cnt     <= r_sh_len_m1;
                        r_trig    <= 1'b1;
                        r_rem     <= r_rem - REP_W'(1);
                        r_win_idx <= r_win_idx + REP_W'(1);
                    end
                end
                S_GAP: begin
                    if (w_cnt_zero) begin
                        r_state   <= S_ACTIVE;
                        r_cnt     <= r_sh_len_m1;
                        r_enable  <= r_sh_mask;
                        r_trig    <= 1'b1;
                        r_rem     <= r_rem - REP_W'(1);
                        r_win_idx <= r_win_idx + REP_W'(1);
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_enable <= '0;
                    r_trig   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign o_enable   = r_enable;
    assign o_trig_out = r_trig;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_win_idx  = r_win_idx;

endmodule

`default_nettype wire

// File: tb/tb_sca_exec_window_ctrl.sv
// ============================================================================
// Module      : tb_sca_exec_window_ctrl
// Description : Self-checking bench for sca_exec_window_ctrl. A timeline model
//               derives every expected output from the elapsed cycle count of
//               the current run using closed-form window arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sca_exec_window_ctrl;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 8;
    localparam int REP_W   = 4;
    localparam int DEF_LEN = 6;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic              i_abort;
    logic              i_cfg_we;
    logic [CNT_W-1:0]  i_cfg_delay;
    logic [CNT_W-1:0]  i_cfg_len;
    logic [CNT_W-1:0]  i_cfg_gap;
    logic [REP_W-1:0]  i_cfg_rep;
    logic [NUM_CH-1:0] i_cfg_mask;
    logic [NUM_CH-1:0] o_enable;
    logic              o_trig_out;
    logic              o_busy;
    logic              o_done;
    logic [REP_W-1:0]  o_win_idx;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_cfg_delay, m_cfg_len, m_cfg_gap, m_cfg_rep, m_cfg_mask;
    bit m_run;
    int m_t;
    int m_delay, m_len, m_gap, m_rep, m_mask;
    int m_last_idx;

    sca_exec_window_ctrl #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .REP_W  (REP_W),
        .DEF_LEN(DEF_LEN)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (i_start),
        .i_abort    (i_abort),
        .i_cfg_we   (i_cfg_we),
        .i_cfg_delay(i_cfg_delay),
        .i_cfg_len  (i_cfg_len),
        .i_cfg_gap  (i_cfg_gap),
        .i_cfg_rep  (i_cfg_rep),
        .i_cfg_mask (i_cfg_mask),
        .o_enable   (o_enable),
        .o_trig_out (o_trig_out),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_win_idx  (o_win_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cfg_delay = 0;
        m_cfg_len   = DEF_LEN;
        m_cfg_gap   = 0;
        m_cfg_rep   = 1;
        m_cfg_mask  = (1 << NUM_CH) - 1;
        m_run       = 1'b0;
        m_t         = 0;
        m_last_idx  = 0;
    endtask

    // Cycle (relative to start) in which done pulses
    function automatic int done_time();
        return 1 + m_delay + (m_rep - 1) * (m_len + m_gap) + m_len;
    endfunction

    // Expected outputs for the current cycle, from the run timeline
    task automatic expect_now(output int en, output int tr, output int bz,
                              output int dn, output int ix);
        int first, k, off, per;
        en = 0; tr = 0; bz = 0; dn = 0; ix = m_last_idx;
        if (m_run) begin
            bz    = 1;
            dn    = (m_t == done_time()) ? 1 : 0;
            ix    = 0;
            first = 1 + m_delay;
            per   = m_len + m_gap;
            if (m_t >= first) begin
                k   = (m_t - first) / per;
                off = (m_t - first) % per;
                if (k >= m_rep) begin
                    ix = m_rep - 1;
                end else begin
                    ix = k;
                    en = (off < m_len) ? m_mask : 0;
                    tr = (off == 0 && dn == 0) ? 1 : 0;
                end
            end
        end
    endtask

    // Check this cycle's outputs, apply inputs for this cycle, advance one clock
    task automatic step(input bit st, input bit ab, input bit we,
                        input int d, input int l, input int g, input int r, input int m);
        int en, tr, bz, dn, ix;
        expect_now(en, tr, bz, dn, ix);
        if (m_run) m_last_idx = ix;
        check_val("enable",  32'(o_enable),   32'(en));
        check_val("trig",    32'(o_trig_out), 32'(tr));
        check_val("busy",    32'(o_busy),     32'(bz));
        check_val("done",    32'(o_done),     32'(dn));
        check_val("win_idx", 32'(o_win_idx),  32'(ix));

        i_start     = st;
        i_abort     = ab;
        i_cfg_we    = we;
        i_cfg_delay = d[CNT_W-1:0];
        i_cfg_len   = l[CNT_W-1:0];
        i_cfg_gap   = g[CNT_W-1:0];
        i_cfg_rep   = r[REP_W-1:0];
        i_cfg_mask  = m[NUM_CH-1:0];

        if (m_run) begin
            if (ab) begin
                m_run = 1'b0;
            end else begin
                m_t++;
                if (m_t > done_time()) m_run = 1'b0;
            end
        end else begin
            if (we) begin
                m_cfg_delay = d % (1 << CNT_W);
                m_cfg_len   = l % (1 << CNT_W);
                m_cfg_gap   = g % (1 << CNT_W);
                m_cfg_rep   = r % (1 << REP_W);
                m_cfg_mask  = m % (1 << NUM_CH);
            end
            if (st && !ab) begin
                m_delay    = m_cfg_delay;
                m_len      = (m_cfg_len == 0) ? 1 : m_cfg_len;
                m_gap      = m_cfg_gap;
                m_rep      = (m_cfg_rep == 0) ? 1 : m_cfg_rep;
                m_mask     = m_cfg_mask;
                m_run      = 1'b1;
                m_t        = 1;
                m_last_idx = 0;
            end
        end

        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int d, input int l, input int g, input int r, input int m);
        step(0, 0, 1, d, l, g, r, m);
    endtask

    task automatic go();
        step(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_start = 0; i_abort = 0; i_cfg_we = 0;
        i_cfg_delay = '0; i_cfg_len = '0; i_cfg_gap = '0; i_cfg_rep = '0; i_cfg_mask = '0;
        model_reset();
        @(negedge clk);
        idle(2);
        rst_n = 1'b1;

        // Defaults: legacy 6-cycle window on all channels
        idle(2);
        go();
        idle(9);

        // Start re-pulsed and config written mid-run: run unaffected
        go();
        step(1, 0, 1, 0, 9, 0, 1, 15);
        step(1, 0, 1, 0, 9, 0, 1, 15);
        step(0, 0, 1, 0, 9, 0, 1, 15);
        idle(6);
        go();
        idle(8);
        cfg(0, 9, 0, 1, 15);
        go();
        idle(11);

        // delay 3, len 2, gap 1, rep 3, mask 0101
        cfg(3, 2, 1, 3, 5);
        go();
        idle(14);

        // Abutting windows
        cfg(0, 2, 0, 2, 15);
        go();
        idle(7);

        // Config write and start in the same cycle
        step(1, 0, 1, 1, 3, 2, 2, 10);
        idle(12);

        // Abort during second window, then a normal run
        cfg(0, 3, 1, 3, 15);
        go();
        idle(5);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        idle(2);
        step(1, 1, 0, 0, 0, 0, 0, 0);   // abort wins over start in idle
        idle(2);
        go();
        idle(14);

        // Zero length / zero repeat => single 1-cycle window; zero mask
        cfg(0, 0, 0, 0, 3);
        go();
        idle(4);
        cfg(1, 2, 1, 2, 0);
        go();
        idle(8);

        // Asynchronous reset mid-window
        cfg(1, 8, 0, 1, 15);
        go();
        idle(4);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_enable",  32'(o_enable),   32'd0);
        check_val("rst_busy",    32'(o_busy),     32'd0);
        check_val("rst_trig",    32'(o_trig_out), 32'd0);
        check_val("rst_win_idx", 32'(o_win_idx),  32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        go();
        idle(9);

        // Randomized traffic
        for (int c = 0; c < 2500; c++) begin
            bit st, ab, we;
            st = ($urandom % 5) == 0;
            ab = ($urandom % 50) == 0;
            we = ($urandom % 6) == 0;
            step(st, ab, we, int'($urandom % 5), int'($urandom % 5),
                 int'($urandom % 3), int'($urandom % 5), int'($urandom % 16));
        end
        idle(40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
